// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one valid functional-unit result per cycle
// and broadcasts it as a registered beat. Sources listed in WIDE_MASK may send
// a 2-beat (low then high) result. Selection is fixed-priority or round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | arbitrate among valid sources, accept at most one per cycle
// HI_PEND | high beat of a wide result is buffered; every src_ready held low
module cdb_arbiter #(
    parameter int                 N_SRC     = 6,
    parameter int                 DATA_W    = 32,
    parameter int                 TAG_W     = 4,
    parameter logic [N_SRC-1:0]   WIDE_MASK = 6'b011000,
    parameter int                 RR_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC-1:0]          src_valid,
    output logic [N_SRC-1:0]          src_ready,
    input  logic [N_SRC-1:0]          src_wide,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [N_SRC*DATA_W-1:0]   src_data_hi,
    input  logic [N_SRC*TAG_W-1:0]    src_tag,
    output logic                      cdb_valid,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic                      cdb_hi,
    output logic                      cdb_last
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SRC - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        HI_PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  hi_buf_q, hi_buf_d;
    logic [TAG_W-1:0]   tag_buf_q, tag_buf_d;

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W:0]     cand;
    logic               grant;

    logic [DATA_W-1:0]  sel_lo, sel_hi;
    logic [TAG_W-1:0]   sel_tag;
    logic               sel_wide;

    logic               nxt_valid, nxt_hi, nxt_last;
    logic [DATA_W-1:0]  nxt_data;
    logic [TAG_W-1:0]   nxt_tag;

    // Find the winning source: lowest index, or first valid at/after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (RR_MODE != 0) begin
                cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(N_SRC)) begin
                    cand = cand - (PTR_W+1)'(N_SRC);
                end
            end else begin
                cand = (PTR_W+1)'(k);
            end
            if (!gnt_found && src_valid[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // A grant only happens in IDLE and never while reset is held.
    assign grant = gnt_found && (state_q == IDLE) && !reset;

    // One-hot ready to the winner; depends only on valid, state and pointer.
    always_comb begin
        src_ready = '0;
        if (grant) begin
            src_ready[gnt_idx] = 1'b1;
        end
    end

    // Mux the winner's payload; the wide flag only counts on wide-capable sources.
    always_comb begin
        sel_lo   = '0;
        sel_hi   = '0;
        sel_tag  = '0;
        sel_wide = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_lo   = src_data[i*DATA_W +: DATA_W];
                sel_hi   = src_data_hi[i*DATA_W +: DATA_W];
                sel_tag  = src_tag[i*TAG_W +: TAG_W];
                sel_wide = src_wide[i] & WIDE_MASK[i];
            end
        end
    end

    // Next state, next bus beat, buffer and pointer updates.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        hi_buf_d  = hi_buf_q;
        tag_buf_d = tag_buf_q;
        nxt_valid = 1'b0;
        nxt_data  = '0;
        nxt_tag   = '0;
        nxt_hi    = 1'b0;
        nxt_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    nxt_valid = 1'b1;
                    nxt_data  = sel_lo;
                    nxt_tag   = sel_tag;
                    rr_ptr_d  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
                    if (sel_wide) begin
                        nxt_last  = 1'b0;
                        hi_buf_d  = sel_hi;
                        tag_buf_d = sel_tag;
                        state_d   = HI_PEND;
                    end else begin
                        nxt_last  = 1'b1;
                    end
                end
            end
            HI_PEND: begin
                nxt_valid = 1'b1;
                nxt_data  = hi_buf_q;
                nxt_tag   = tag_buf_q;
                nxt_hi    = 1'b1;
                nxt_last  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, buffers and the registered bus; reset drops any pending high beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            hi_buf_q  <= '0;
            tag_buf_q <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            cdb_hi    <= 1'b0;
            cdb_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            hi_buf_q  <= hi_buf_d;
            tag_buf_q <= tag_buf_d;
            cdb_valid <= nxt_valid;
            cdb_data  <= nxt_data;
            cdb_tag   <= nxt_tag;
            cdb_hi    <= nxt_hi;
            cdb_last  <= nxt_last;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo core. It collects results from N functional-unit sources (adders, multipliers, memory) and broadcasts exactly one tagged result per cycle to the reservation stations and register file. Each source uses a valid/ready handshake, so a source that loses arbitration holds its result instead of having it dropped. Fixed-priority or round-robin selection is chosen by parameter, and designated wide sources can broadcast a 2-beat (low/high) 64-bit result.

## Interface
- N_SRC, 6, number of source channels; index 0..N_SRC-1 (default map: 0-2 adders, 3-4 multipliers, 5 memory)
- DATA_W, 32, width of one data beat
- TAG_W, 4, reservation-station tag width
- WIDE_MASK, 6'b011000, N_SRC-bit mask; bit i=1 means channel i may issue 2-beat results
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- src_valid  in  N_SRC  channel i has a result pending
- src_ready  out  N_SRC  channel i's result is accepted this cycle (combinational, one-hot or zero)
- src_wide  in  N_SRC  channel i's result is 2-beat; ignored where WIDE_MASK[i]=0
- src_data  in  N_SRC*DATA_W  low/only beat, channel i at [i*DATA_W +: DATA_W]
- src_data_hi  in  N_SRC*DATA_W  high beat, same packing; used only for wide transfers
- src_tag  in  N_SRC*TAG_W  producing tag, channel i at [i*TAG_W +: TAG_W]
- cdb_valid  out  1  broadcast valid (registered)
- cdb_data  out  DATA_W  broadcast data (registered)
- cdb_tag  out  TAG_W  broadcast tag (registered)
- cdb_hi  out  1  1 = this beat is the high half of a wide result
- cdb_last  out  1  1 = final beat of the result (always 1 for single-beat results)

## Operation
- **Handshake:** a transfer occurs on a rising edge where src_valid[i] & src_ready[i] = 1. The source holds valid, data, data_hi, tag and wide stable until accepted. The arbiter never applies backpressure to bus consumers.
- **States:**
  - IDLE: arbitrate normally.
  - HI_PEND: the high beat of an accepted wide result is buffered; all src_ready are 0.
- **Arbitration in IDLE:**
  - Candidates are the channels with src_valid=1.
  - RR_MODE=0: grant the lowest index.
  - RR_MODE=1: grant the first valid index at or above rr_ptr, searching upward with wrap past N_SRC-1 to 0.
  - At most one src_ready is high. No valid channel gives src_ready=0 everywhere.
- **rr_ptr:** on a grant to channel g, rr_ptr <= (g+1) mod N_SRC. It is unchanged when there is no grant and in HI_PEND. It is unused in fixed mode.
- **Single-beat accept** (src_wide[g]=0 or WIDE_MASK[g]=0):
  - Next edge: cdb_valid=1, cdb_data=low beat, cdb_tag=tag, cdb_hi=0, cdb_last=1.
  - State stays IDLE.
- **Wide accept** (src_wide[g]=1 and WIDE_MASK[g]=1):
  - Next edge: cdb_valid=1, cdb_data=low beat, cdb_hi=0, cdb_last=0. hi_buf <= src_data_hi, tag_buf <= tag, state -> HI_PEND.
  - Following edge: cdb_valid=1, cdb_data=hi_buf, cdb_tag=tag_buf, cdb_hi=1, cdb_last=1, state -> IDLE.
- **No grant:** cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_hi=0, cdb_last=0. The bus is zeroed when idle.
- **Simultaneous valids:** losers keep src_valid high and are served in later cycles. No result is lost or duplicated.

## Timing
- **Reset values:** cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_hi=0, cdb_last=0, state=IDLE, rr_ptr=0, hi_buf=0, tag_buf=0. src_ready=0 while reset is asserted.
- **Latency:** accept edge t -> beat on bus after edge t (visible in cycle t+1). Wide high beat is visible in cycle t+2.
- **Throughput:** 1 beat/cycle. A new grant may occur in the cycle the high beat is on the bus (state is IDLE then), so the buses are back-to-back with no bubble.
- **src_ready path:** src_ready is combinational from src_valid, state and rr_ptr. It has no dependency on the src_data inputs.
- **Reset mid-wide:** reset asserted in HI_PEND discards the buffered high beat. No high beat appears after reset is released.
- **Wrap:** when g=N_SRC-1, rr_ptr wraps to 0.

## Test plan
- **Reset:** assert reset with all src_valid=1 -> all outputs 0 and src_ready=0. After release in fixed mode, first grant is channel 0.
- **Fixed priority:** src_valid=6'b100110, hold all -> grants 1, 2, 5 on successive cycles. cdb_tag shows each channel's tag one cycle after its grant. Channel 5 data 32'hDEAD_0005 appears third.
- **Round-robin** (RR_MODE=1): all 6 valid continuously -> grant order 0,1,2,3,4,5,0. Drop channel 1 after its first grant and restart with rr_ptr=1 -> the next grant goes to 2.
- **Wide transfer:** channel 3, src_wide=1, low 32'h1111_2222, hi 32'h3333_4444, tag 4'hA; channel 0 valid one cycle later.
  - Required: cycle t+1 shows low beat, cdb_hi=0, cdb_last=0, all src_ready=0.
  - Cycle t+2 shows 32'h3333_4444, tag 4'hA, cdb_hi=1, cdb_last=1, src_ready[0]=1.
  - Channel 0's beat appears in cycle t+3.
- **Non-wide channel:** src_wide=1 on channel 0 (WIDE_MASK[0]=0) -> single beat, cdb_last=1, no high beat.
- **Reset in HI_PEND:** assert reset in cycle t+1 of a wide transfer -> outputs 0 immediately, no high beat after release, state IDLE.
